// File: rtl/dispatch_stage_if.sv
// Decode-to-dispatch handshake bundle.
// The master drives a decoded instruction; the slave answers with in_ready.
interface dispatch_stage_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] immediate;
    logic [TAG_W:0]    rs1_tag;
    logic [TAG_W:0]    rs2_tag;
    logic [TAG_W-1:0]  rd_tag;

    modport master (
        output in_valid, opcode, func3, func7, rs1, rs2,
        output rs1_data, rs2_data, immediate,
        output rs1_tag, rs2_tag, rd_tag,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, func3, func7, rs1, rs2,
        input  rs1_data, rs2_data, immediate,
        input  rs1_tag, rs2_tag, rd_tag,
        output in_ready
    );
endinterface

// File: rtl/dispatch_stage.sv
// Credit-aware dispatch stage: classifies, resolves operands and holds
// one instruction (snooping the CDB) until its target queue has credit.
module dispatch_stage #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int QDEPTH    = 4,
    parameter int MULDIV_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dispatch_stage_if.slave   dec,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [3:0]        q_deq,
    input  logic              br_resolve,
    input  logic              flush,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic              out_rs1_vld,
    output logic              out_rs2_vld,
    output logic [TAG_W-1:0]  out_rs1_tag,
    output logic [TAG_W-1:0]  out_rs2_tag,
    output logic [TAG_W-1:0]  out_rd_tag,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_func3,
    output logic [6:0]        out_func7,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_st,
    output logic              credit_err
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic              rs1_vld;
        logic              rs2_vld;
        logic [TAG_W-1:0]  rs1_tag;
        logic [TAG_W-1:0]  rs2_tag;
        logic [TAG_W-1:0]  rd_tag;
        logic              st;
    } slot_t;

    typedef enum logic {RUN, BR_WAIT} state_t;

    state_t     state, state_n;
    slot_t      stg, nxt;
    logic       stg_vld;
    logic [3:0] stg_q, q_sel, has_cr, ovf;
    logic       fire, accept;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jalr;
    logic       is_lui, is_auipc, is_mul, is_div, to_int;
    logic       hit1, hit2, snoop1, snoop2;

    assign is_r     = dec.opcode == OP_R;
    assign is_i     = dec.opcode == OP_I;
    assign is_ld    = dec.opcode == OP_LD;
    assign is_st    = dec.opcode == OP_ST;
    assign is_br    = dec.opcode == OP_BR;
    assign is_jalr  = dec.opcode == OP_JALR;
    assign is_lui   = dec.opcode == OP_LUI;
    assign is_auipc = dec.opcode == OP_AUIPC;
    assign is_mul   = is_r && dec.func7 == 7'd1 && dec.func3 == 3'd0;
    assign is_div   = is_r && dec.func7 == 7'd1 && dec.func3 == 3'd4;
    assign to_int   = (is_r && !is_mul && !is_div) || is_i || is_br
                    || is_jalr || is_lui || is_auipc;

    // JAL and unknown opcodes select no queue and are simply dropped
    always_comb begin
        q_sel = 4'b0000;
        unique case (1'b1)
            is_mul:       q_sel = (MULDIV_EN != 0) ? 4'b0010 : 4'b0001;
            is_div:       q_sel = (MULDIV_EN != 0) ? 4'b0100 : 4'b0001;
            is_ld, is_st: q_sel = 4'b1000;
            to_int:       q_sel = 4'b0001;
            default:      q_sel = 4'b0000;
        endcase
    end

    assign hit1 = cdb_valid && cdb_tag == dec.rs1_tag[TAG_W-1:0];
    assign hit2 = cdb_valid && cdb_tag == dec.rs2_tag[TAG_W-1:0];

    always_comb begin
        nxt          = '0;
        nxt.opcode   = dec.opcode;
        nxt.func3    = dec.func3;
        nxt.func7    = dec.func7;
        nxt.imm      = dec.immediate;
        nxt.rs1_tag  = dec.rs1_tag[TAG_W-1:0];
        nxt.rs2_tag  = dec.rs2_tag[TAG_W-1:0];
        nxt.rd_tag   = dec.rd_tag;
        nxt.st       = is_st;
        if (dec.rs1 == 5'd0) begin
            nxt.rs1_vld  = 1'b1;
            nxt.rs1_data = '0;
        end else if (hit1) begin
            nxt.rs1_vld  = 1'b1;
            nxt.rs1_data = cdb_data;
        end else begin
            nxt.rs1_vld  = ~dec.rs1_tag[TAG_W];
            nxt.rs1_data = dec.rs1_data;
        end
        if (dec.rs2 == 5'd0) begin
            nxt.rs2_vld  = 1'b1;
            nxt.rs2_data = '0;
        end else if (hit2) begin
            nxt.rs2_vld  = 1'b1;
            nxt.rs2_data = cdb_data;
        end else begin
            nxt.rs2_vld  = ~dec.rs2_tag[TAG_W];
            nxt.rs2_data = dec.rs2_data;
        end
        if (is_i || is_lui) begin
            nxt.rs2_vld  = 1'b1;
            nxt.rs2_data = dec.immediate;
        end else if (is_ld) begin
            nxt.rs2_vld  = 1'b1;
        end
    end

    assign fire      = stg_vld && !flush && |(stg_q & has_cr);
    assign out_valid = fire ? stg_q : 4'b0000;
    assign dec.in_ready = state == RUN && !flush && (!stg_vld || fire);
    assign accept    = dec.in_valid && dec.in_ready;

    assign snoop1 = !stg.rs1_vld && cdb_valid && cdb_tag == stg.rs1_tag;
    assign snoop2 = !stg.rs2_vld && cdb_valid && cdb_tag == stg.rs2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= 1'b0;
            stg_q   <= 4'b0000;
            stg     <= '0;
        end else if (flush) begin
            stg_vld <= 1'b0;
        end else if (accept) begin
            stg_vld <= |q_sel;
            stg_q   <= q_sel;
            if (|q_sel) stg <= nxt;
        end else if (fire) begin
            stg_vld <= 1'b0;
        end else if (stg_vld) begin
            if (snoop1) begin
                stg.rs1_vld  <= 1'b1;
                stg.rs1_data <= cdb_data;
            end
            if (snoop2) begin
                stg.rs2_vld  <= 1'b1;
                stg.rs2_data <= cdb_data;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cr
        logic [CW-1:0] cnt;
        logic          take;
        assign take      = fire && stg_q[g];
        assign has_cr[g] = cnt != '0;
        assign ovf[g]    = q_deq[g] && !take && cnt == FULL;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= FULL;
            else if (q_deq[g] && !take && cnt != FULL)
                cnt <= cnt + 1'b1;
            else if (take && !q_deq[g])
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      credit_err <= 1'b0;
        else if (|ovf)   credit_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RUN:     if (accept && (is_br || is_jalr)) state_n = BR_WAIT;
            BR_WAIT: if (br_resolve || flush)          state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    assign out_rs1_data = stg.rs1_data;
    assign out_rs2_data = stg.rs2_data;
    assign out_rs1_vld  = stg.rs1_vld;
    assign out_rs2_vld  = stg.rs2_vld;
    assign out_rs1_tag  = stg.rs1_tag;
    assign out_rs2_tag  = stg.rs2_tag;
    assign out_rd_tag   = stg.rd_tag;
    assign out_opcode   = stg.opcode;
    assign out_func3    = stg.func3;
    assign out_func7    = stg.func7;
    assign out_imm      = stg.imm;
    assign out_st       = stg.st;
endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Registered, credit-aware dispatch stage between rename/decode and the four reservation-station FIFOs (integer, multiply, divide, load/store). It classifies each decoded instruction and resolves operand readiness, including register x0 and CDB bypass. It holds the instruction in a one-entry stage that keeps snooping the CDB until the target queue has a free slot. A branch-stall FSM replaces the external stall/one-shot pair, and per-queue credit counters replace downstream full checks.

## Interface
- DATA_W, 32, operand/immediate width
- TAG_W, 6, ROB tag width; source tags carry an extra MSB "pending" bit
- QDEPTH, 4, entries per downstream queue = initial credits (>=1)
- MULDIV_EN, 1, 0 routes mult/div to the integer queue
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  decode handshake
- opcode, func3, func7  in  7, 3, 7  decoded fields
- rs1, rs2  in  5  source indices; rs1_data, rs2_data, immediate  in  DATA_W
- rs1_tag, rs2_tag  in  TAG_W+1  MSB=1 means operand pending; rd_tag  in  TAG_W
- cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  DATA_W
- q_deq  in  4  per-queue slot-release pulse, order {ldst,div,mult,int}
- br_resolve, flush  in  1  branch resolved / pipeline flush
- out_valid  out  4  one-hot dispatch strobe
- out_rs1_data, out_rs2_data  out  DATA_W; out_rs1_vld, out_rs2_vld  out  1
- out_rs1_tag, out_rs2_tag, out_rd_tag  out  TAG_W; out_opcode/func3/func7/imm  out  as inputs; out_st  out  1 (1 = store)
- credit_err  out  1  sticky: q_deq received while credit already at QDEPTH

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Routing:
  - R with func7=1, func3=0 -> mult.
  - R with func7=1, func3=4 -> div (both to int when MULDIV_EN=0).
  - LOAD/STORE -> ldst.
  - R, I, BRANCH, JALR, LUI, AUIPC -> int.
  - JAL and unknown opcodes are accepted and dropped: no stage fill, no credit use.
- Operand valid on accept: rsN==0 -> valid, data 0; otherwise CDB match (cdb_valid, cdb_tag==rsN_tag[TAG_W-1:0]) -> valid with cdb_data; otherwise valid = ~rsN_tag[TAG_W].
- I/LUI: rs2 data = immediate, valid 1. LOAD: rs2 valid 1.
- While the stage is held, each invalid operand whose tag matches a valid CDB captures cdb_data and sets valid at the next edge.
- Credits: one counter per queue, width clog2(QDEPTH+1), reset QDEPTH.
  - Fire decrements; q_deq increments; both in the same cycle leave it unchanged.
  - Increment saturates at QDEPTH and sets credit_err.
- Fire = stage_valid && credit[q]!=0. out_valid[q]=fire, combinational from registers.
- FSM RUN/BR_WAIT:
  - Accepting BRANCH or JALR moves RUN -> BR_WAIT.
  - BR_WAIT -> RUN on br_resolve or flush.
  - br_resolve in RUN is ignored.
- in_ready = state==RUN && !flush && (!stage_valid || fire).
- flush clears the stage (no fire that cycle) and forces RUN. Credits are unaffected.

## Timing
- Reset: stage empty, out_valid=0, out payload 0, state RUN, credits QDEPTH, credit_err 0. in_ready=1 in the first cycle after deassertion.
- Latency: accepted at edge N -> out_valid high during cycle N+1 if credit is available. Otherwise the stage holds until credit returns.
- Back-to-back throughput is 1/cycle while credits last.
- A CDB broadcast in the same cycle as fire is not reflected in the output; the downstream queue snoops it itself.
- After a branch is accepted at edge N, in_ready is 0 from cycle N+1. A br_resolve pulse in cycle M gives in_ready=1 in cycle M+1.
- Asserting reset mid-hold drops the held instruction and restores all credits.

## Test plan
- Issue ADD, then MUL (func7=1, func3=0) -> out_valid=0001 at cycle 1, then 0010 at cycle 2. With MULDIV_EN=0 the MUL gives 0001.
- QDEPTH=4: five int ops with no q_deq -> four fire, fifth held with in_ready=0. q_deq[0] pulse -> fifth fires the next cycle.
- Held op with rs1_tag=7'h45 pending; CDB tag 5, data 32'hDEAD_BEEF -> dispatched with rs1_vld=1, rs1_data=DEADBEEF.
- Accept BEQ -> in_ready low. br_resolve at cycle 5 -> next accept at cycle 6. flush while held -> no out_valid, credits unchanged.
- rs1=0 with rs1_tag pending -> rs1_vld=1, data 0. JAL -> accepted, no out_valid, credits unchanged.
- q_deq[2] at full credit -> credit_err=1 and stays set; fire plus q_deq in the same cycle leaves the count unchanged.
